// File: rtl/vproc_div_res_pack_pkg.sv
// Shared types for the divide-result packing stage.
package vproc_div_res_pack_pkg;

  // Control travelling with each divider chunk; last_cycle closes the current word early.
  typedef struct packed {
    logic [3:0] id;
    logic       last_cycle;
  } ctrl_t;

endpackage

// File: rtl/vproc_div_res_pack_if.sv
// Ready/valid bundle between the divide unit, the packing stage and the writeback path.
interface vproc_div_res_pack_if #(
  parameter int unsigned DIV_OP_W = 64,
  parameter int unsigned RES_W    = 128,
  parameter type         CTRL_T   = vproc_div_res_pack_pkg::ctrl_t
);

  logic                 pipe_in_valid_i;
  logic                 pipe_in_ready_o;
  CTRL_T                pipe_in_ctrl_i;
  logic [DIV_OP_W-1:0]  pipe_in_res_i;
  logic [DIV_OP_W/8-1:0] pipe_in_mask_i;

  logic                 pipe_out_valid_o;
  logic                 pipe_out_ready_i;
  CTRL_T                pipe_out_ctrl_o;
  logic [RES_W-1:0]     pipe_out_res_o;
  logic [RES_W/8-1:0]   pipe_out_mask_o;

  // Packing-stage side
  modport slave (
    input  pipe_in_valid_i, pipe_in_ctrl_i, pipe_in_res_i, pipe_in_mask_i, pipe_out_ready_i,
    output pipe_in_ready_o, pipe_out_valid_o, pipe_out_ctrl_o, pipe_out_res_o, pipe_out_mask_o
  );

  // Producer/consumer side
  modport master (
    output pipe_in_valid_i, pipe_in_ctrl_i, pipe_in_res_i, pipe_in_mask_i, pipe_out_ready_i,
    input  pipe_in_ready_o, pipe_out_valid_o, pipe_out_ctrl_o, pipe_out_res_o, pipe_out_mask_o
  );

endinterface

// File: rtl/vproc_div_res_pack.sv
// Packs consecutive DIV_OP_W divider chunks (slot 0 = LSBs) into RES_W words,
// flushing early on last_cycle; fully registered output with ready/valid on both sides.
module vproc_div_res_pack #(
  parameter int unsigned DIV_OP_W = 64,
  parameter int unsigned RES_W    = 128,
  parameter type         CTRL_T   = vproc_div_res_pack_pkg::ctrl_t
) (
  input  logic                 clk_i,
  input  logic                 async_rst_ni,
  vproc_div_res_pack_if.slave  pipe
);

  localparam int unsigned N      = RES_W / DIV_OP_W;
  localparam int unsigned MASK_W = DIV_OP_W / 8;
  localparam int unsigned RMSK_W = RES_W / 8;
  localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;

  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [RES_W-1:0]  r_asm_res, w_asm_res_nxt, w_merge_res;
  logic [RMSK_W-1:0] r_asm_mask, w_asm_mask_nxt, w_merge_mask;
  logic [RES_W-1:0]  r_out_res, w_out_res_nxt;
  logic [RMSK_W-1:0] r_out_mask, w_out_mask_nxt;
  CTRL_T             r_out_ctrl, w_out_ctrl_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              w_in_ready, w_acc, w_done, w_drain;

  // Output slot frees up either when empty or when it drains this cycle.
  assign w_in_ready = ~r_out_valid | pipe.pipe_out_ready_i;
  assign w_acc      = pipe.pipe_in_valid_i & w_in_ready;
  assign w_drain    = r_out_valid & pipe.pipe_out_ready_i;
  assign w_done     = w_acc & ((r_cnt == CNT_W'(N - 1)) | pipe.pipe_in_ctrl_i.last_cycle);

  // Slots above cnt are already zero because the buffer is cleared on every completion.
  always_comb begin
    w_merge_res  = r_asm_res;
    w_merge_mask = r_asm_mask;
    for (int unsigned s = 0; s < N; s++) begin
      if (r_cnt == CNT_W'(s)) begin
        w_merge_res[s*DIV_OP_W +: DIV_OP_W] = pipe.pipe_in_res_i;
        w_merge_mask[s*MASK_W +: MASK_W]    = pipe.pipe_in_mask_i;
      end
    end
  end

  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_asm_res_nxt   = r_asm_res;
    w_asm_mask_nxt  = r_asm_mask;
    w_out_res_nxt   = r_out_res;
    w_out_mask_nxt  = r_out_mask;
    w_out_ctrl_nxt  = r_out_ctrl;
    w_out_valid_nxt = r_out_valid;
    if (w_done) begin
      w_cnt_nxt       = '0;
      w_asm_res_nxt   = '0;
      w_asm_mask_nxt  = '0;
      w_out_res_nxt   = w_merge_res;
      w_out_mask_nxt  = w_merge_mask;
      w_out_ctrl_nxt  = pipe.pipe_in_ctrl_i;
      w_out_valid_nxt = 1'b1;
    end else begin
      if (w_acc) begin
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        w_asm_res_nxt  = w_merge_res;
        w_asm_mask_nxt = w_merge_mask;
      end
      if (w_drain) begin
        w_out_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_cnt       <= '0;
      r_asm_res   <= '0;
      r_asm_mask  <= '0;
      r_out_res   <= '0;
      r_out_mask  <= '0;
      r_out_ctrl  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_asm_res   <= w_asm_res_nxt;
      r_asm_mask  <= w_asm_mask_nxt;
      r_out_res   <= w_out_res_nxt;
      r_out_mask  <= w_out_mask_nxt;
      r_out_ctrl  <= w_out_ctrl_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign pipe.pipe_in_ready_o  = w_in_ready;
  assign pipe.pipe_out_valid_o = r_out_valid;
  assign pipe.pipe_out_res_o   = r_out_res;
  assign pipe.pipe_out_mask_o  = r_out_mask;
  assign pipe.pipe_out_ctrl_o  = r_out_ctrl;

endmodule
